// File: rtl/multicycle_control_fsm.sv
// Main control FSM of the 16-bit multi-cycle core: fetch/decode/execute/mem/wb.
// Optional PERF_CNT_EN adds retired_cnt and cycle_cnt counters.
module multicycle_control_fsm #(
  parameter int OPC_W = 7,
  parameter int ST_W  = 4
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [OPC_W-1:0] opcode,
  input  logic             alu_zero,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             ir_write,
  output logic             iord,
  output logic             mem_write,
  output logic             reg_write,
  output logic             mem_to_reg,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [1:0]       pc_source,
  output logic             illegal_op,
  output logic [ST_W-1:0]  state_dbg
`ifdef PERF_CNT_EN
  ,
  output logic [15:0]      retired_cnt,
  output logic [15:0]      cycle_cnt
`endif
);

  typedef enum logic [3:0] {
    INIT      = 4'd0,
    FETCH     = 4'd1,
    DECODE    = 4'd2,
    MEM_ADDR  = 4'd3,
    MEM_READ  = 4'd4,
    MEM_WB    = 4'd5,
    MEM_WRITE = 4'd6,
    R_EXEC    = 4'd7,
    R_WB      = 4'd8,
    I_EXEC    = 4'd9,
    I_WB      = 4'd10,
    BRANCH    = 4'd11,
    JUMP      = 4'd12
  } state_e;

  localparam logic [OPC_W-1:0] OP_R    = OPC_W'(0);
  localparam logic [OPC_W-1:0] OP_ADDI = OPC_W'(1);
  localparam logic [OPC_W-1:0] OP_LW   = OPC_W'(2);
  localparam logic [OPC_W-1:0] OP_SW   = OPC_W'(3);
  localparam logic [OPC_W-1:0] OP_BEQ  = OPC_W'(4);
  localparam logic [OPC_W-1:0] OP_BNE  = OPC_W'(5);
  localparam logic [OPC_W-1:0] OP_J    = OPC_W'(6);

  state_e state_q, state_d;
  logic   retire;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      INIT:      state_d = FETCH;
      FETCH:     if (mem_ready) state_d = DECODE;
      DECODE: begin
        case (opcode)
          OP_R:           state_d = R_EXEC;
          OP_ADDI:        state_d = I_EXEC;
          OP_LW, OP_SW:   state_d = MEM_ADDR;
          OP_BEQ, OP_BNE: state_d = BRANCH;
          OP_J:           state_d = JUMP;
          default:        state_d = FETCH;
        endcase
      end
      MEM_ADDR:  state_d = (opcode == OP_SW) ? MEM_WRITE : MEM_READ;
      MEM_READ:  if (mem_ready) state_d = MEM_WB;
      MEM_WRITE: if (mem_ready) state_d = FETCH;
      R_EXEC:    state_d = R_WB;
      I_EXEC:    state_d = I_WB;
      MEM_WB, R_WB, I_WB, BRANCH, JUMP: state_d = FETCH;
      default:   state_d = INIT;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state_q <= INIT;
    else        state_q <= state_d;
  end

  // Outputs decode from the state register so reset drops every strobe at once
  always_comb begin
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    iord       = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'd0;
    alu_op     = 2'd0;
    pc_source  = 2'd0;
    illegal_op = 1'b0;
    unique case (state_q)
      FETCH: begin
        alu_src_b = 2'd1;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      DECODE: begin
        alu_src_b  = 2'd3;
        illegal_op = (opcode > OP_J);
      end
      MEM_ADDR, I_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'd2;
      end
      MEM_READ:  iord = 1'b1;
      MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      MEM_WRITE: begin
        iord      = 1'b1;
        mem_write = 1'b1;
      end
      R_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = 2'd2;
      end
      R_WB, I_WB: reg_write = 1'b1;
      BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = 2'd1;
        pc_source = 2'd1;
        pc_write  = (opcode == OP_BNE) ? ~alu_zero : alu_zero;
      end
      JUMP: begin
        pc_source = 2'd2;
        pc_write  = 1'b1;
      end
      default: ;
    endcase
  end

  assign state_dbg = ST_W'(state_q);

  always_comb begin
    retire = 1'b0;
    unique case (state_q)
      MEM_WB, R_WB, I_WB, BRANCH, JUMP: retire = 1'b1;
      MEM_WRITE: retire = mem_ready;
      default:   retire = 1'b0;
    endcase
  end

`ifdef PERF_CNT_EN
  logic [15:0] retired_q, cycle_q;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      retired_q <= 16'd0;
      cycle_q   <= 16'd0;
    end else begin
      cycle_q <= cycle_q + 16'd1;
      if (retire) retired_q <= retired_q + 16'd1;
    end
  end

  assign retired_cnt = retired_q;
  assign cycle_cnt   = cycle_q;
`else
  logic unused_retire;
  assign unused_retire = retire;
`endif

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Table-driven bench for multicycle_control_fsm.
// PERF_CNT_EN builds also check the retired/cycle counters.
module tb_multicycle_control_fsm;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic [6:0] opcode = 7'd0;
  logic       alu_zero = 1'b0;
  logic       mem_ready = 1'b1;
  logic       pc_write, ir_write, iord, mem_write, reg_write, mem_to_reg;
  logic       alu_src_a, illegal_op;
  logic [1:0] alu_src_b, alu_op, pc_source;
  logic [3:0] state_dbg;
`ifdef PERF_CNT_EN
  logic [15:0] retired_cnt, cycle_cnt;
`endif

  always #5 CLK = ~CLK;

  multicycle_control_fsm dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .opcode     (opcode),
    .alu_zero   (alu_zero),
    .mem_ready  (mem_ready),
    .pc_write   (pc_write),
    .ir_write   (ir_write),
    .iord       (iord),
    .mem_write  (mem_write),
    .reg_write  (reg_write),
    .mem_to_reg (mem_to_reg),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .alu_op     (alu_op),
    .pc_source  (pc_source),
    .illegal_op (illegal_op),
    .state_dbg  (state_dbg)
`ifdef PERF_CNT_EN
    ,
    .retired_cnt(retired_cnt),
    .cycle_cnt  (cycle_cnt)
`endif
  );

  typedef struct {
    logic        rst_n;
    logic [6:0]  opc;
    logic        z;
    logic        rdy;
    logic [3:0]  st;
    logic [13:0] o;
  } vec_t;

  vec_t vq[$];
  int   passed = 0;
  int   total  = 0;

  logic [13:0] act;
  assign act = {pc_write, ir_write, iord, mem_write, reg_write, mem_to_reg,
                alu_src_a, alu_src_b, alu_op, pc_source, illegal_op};

  function automatic logic [13:0] O(
    input bit pcw, input bit irw, input bit io, input bit mw,
    input bit rw, input bit m2r, input bit sa, input bit [1:0] sb,
    input bit [1:0] aop, input bit [1:0] ps, input bit ill);
    return {pcw, irw, io, mw, rw, m2r, sa, sb, aop, ps, ill};
  endfunction

  task automatic add(input logic r, input logic [6:0] opc, input logic z,
                     input logic rdy, input logic [3:0] st,
                     input logic [13:0] o);
    vec_t v;
    v.rst_n = r; v.opc = opc; v.z = z; v.rdy = rdy; v.st = st; v.o = o;
    vq.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] a,
                     input logic [31:0] e);
    total++;
    if (a === e) passed++;
    else $display("FAIL %s: got %h, expected %h", name, a, e);
  endtask

  initial begin
    logic [13:0] oZ, oF1, oF0, oDec, oIll, oMA, oMR, oMWB, oMW;
    logic [13:0] oRE, oRW, oBr1, oBr0, oJ;
    oZ   = '0;
    oF1  = O(1, 1, 0, 0, 0, 0, 0, 2'd1, 2'd0, 2'd0, 0);
    oF0  = O(0, 0, 0, 0, 0, 0, 0, 2'd1, 2'd0, 2'd0, 0);
    oDec = O(0, 0, 0, 0, 0, 0, 0, 2'd3, 2'd0, 2'd0, 0);
    oIll = O(0, 0, 0, 0, 0, 0, 0, 2'd3, 2'd0, 2'd0, 1);
    oMA  = O(0, 0, 0, 0, 0, 0, 1, 2'd2, 2'd0, 2'd0, 0);
    oMR  = O(0, 0, 1, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 0);
    oMWB = O(0, 0, 0, 0, 1, 1, 0, 2'd0, 2'd0, 2'd0, 0);
    oMW  = O(0, 0, 1, 1, 0, 0, 0, 2'd0, 2'd0, 2'd0, 0);
    oRE  = O(0, 0, 0, 0, 0, 0, 1, 2'd0, 2'd2, 2'd0, 0);
    oRW  = O(0, 0, 0, 0, 1, 0, 0, 2'd0, 2'd0, 2'd0, 0);
    oBr1 = O(1, 0, 0, 0, 0, 0, 1, 2'd0, 2'd1, 2'd1, 0);
    oBr0 = O(0, 0, 0, 0, 0, 0, 1, 2'd0, 2'd1, 2'd1, 0);
    oJ   = O(1, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 2'd2, 0);

    // reset, then R-type with a one-cycle fetch stall afterwards
    add(0, 7'h00, 0, 1, 4'd0,  oZ);
    add(1, 7'h00, 0, 1, 4'd0,  oZ);
    add(1, 7'h00, 0, 1, 4'd1,  oF1);
    add(1, 7'h00, 0, 1, 4'd2,  oDec);
    add(1, 7'h00, 0, 1, 4'd7,  oRE);
    add(1, 7'h00, 0, 1, 4'd8,  oRW);
    add(1, 7'h02, 0, 0, 4'd1,  oF0);
    // LW with three wait cycles in MEM_READ
    add(1, 7'h02, 0, 1, 4'd1,  oF1);
    add(1, 7'h02, 0, 1, 4'd2,  oDec);
    add(1, 7'h02, 0, 1, 4'd3,  oMA);
    add(1, 7'h02, 0, 0, 4'd4,  oMR);
    add(1, 7'h02, 0, 0, 4'd4,  oMR);
    add(1, 7'h02, 0, 0, 4'd4,  oMR);
    add(1, 7'h02, 0, 1, 4'd4,  oMR);
    add(1, 7'h02, 0, 1, 4'd5,  oMWB);
    // ADDI
    add(1, 7'h01, 0, 1, 4'd1,  oF1);
    add(1, 7'h01, 0, 1, 4'd2,  oDec);
    add(1, 7'h01, 0, 1, 4'd9,  oMA);
    add(1, 7'h01, 0, 1, 4'd10, oRW);
    // BEQ taken, BNE not taken, BNE taken
    add(1, 7'h04, 1, 1, 4'd1,  oF1);
    add(1, 7'h04, 1, 1, 4'd2,  oDec);
    add(1, 7'h04, 1, 1, 4'd11, oBr1);
    add(1, 7'h05, 1, 1, 4'd1,  oF1);
    add(1, 7'h05, 1, 1, 4'd2,  oDec);
    add(1, 7'h05, 1, 1, 4'd11, oBr0);
    add(1, 7'h05, 0, 1, 4'd1,  oF1);
    add(1, 7'h05, 0, 1, 4'd2,  oDec);
    add(1, 7'h05, 0, 1, 4'd11, oBr1);
    // J
    add(1, 7'h06, 0, 1, 4'd1,  oF1);
    add(1, 7'h06, 0, 1, 4'd2,  oDec);
    add(1, 7'h06, 0, 1, 4'd12, oJ);
    // illegal opcode: single pulse, back to FETCH
    add(1, 7'h7F, 0, 1, 4'd1,  oF1);
    add(1, 7'h7F, 0, 1, 4'd2,  oIll);
    add(1, 7'h00, 0, 1, 4'd1,  oF1);
    // R-type with opcode changed after DECODE
    add(1, 7'h00, 0, 1, 4'd2,  oDec);
    add(1, 7'h03, 0, 1, 4'd7,  oRE);
    add(1, 7'h03, 0, 1, 4'd8,  oRW);
    // SW, reset asserted mid MEM_WRITE
    add(1, 7'h03, 0, 1, 4'd1,  oF1);
    add(1, 7'h03, 0, 1, 4'd2,  oDec);
    add(1, 7'h03, 0, 1, 4'd3,  oMA);
    add(1, 7'h03, 0, 0, 4'd6,  oMW);
    add(0, 7'h03, 0, 0, 4'd0,  oZ);
    add(1, 7'h03, 0, 1, 4'd0,  oZ);
    add(1, 7'h03, 0, 1, 4'd1,  oF1);
    // SW completing with mem_ready high
    add(1, 7'h03, 0, 1, 4'd2,  oDec);
    add(1, 7'h03, 0, 1, 4'd3,  oMA);
    add(1, 7'h03, 0, 1, 4'd6,  oMW);
    add(1, 7'h03, 0, 1, 4'd1,  oF1);

    for (int i = 0; i < vq.size(); i++) begin
      @(negedge CLK);
      RST_N     = vq[i].rst_n;
      opcode    = vq[i].opc;
      alu_zero  = vq[i].z;
      mem_ready = vq[i].rdy;
      #1;
      total++;
      if (state_dbg === vq[i].st && act === vq[i].o) passed++;
      else $display("FAIL vec%0d: state=%0d out=%h, expected state=%0d out=%h",
                    i, state_dbg, act, vq[i].st, vq[i].o);
    end

`ifdef PERF_CNT_EN
    // R, SW, J after reset: INIT + 4 + 4 + 3 = 12 cycles, 3 retired
    @(negedge CLK);
    RST_N = 1'b0;
    opcode = 7'h00;
    mem_ready = 1'b1;
    #1;
    chk("cycle_cnt_rst", 32'(cycle_cnt), 32'd0);
    chk("retired_cnt_rst", 32'(retired_cnt), 32'd0);
    @(negedge CLK);
    RST_N = 1'b1;
    for (int c = 0; c < 12; c++) begin
      opcode = (c < 5) ? 7'h00 : (c < 10) ? 7'h03 : 7'h06;
      @(negedge CLK);
    end
    #1;
    chk("cycle_cnt", 32'(cycle_cnt), 32'd12);
    chk("retired_cnt", 32'(retired_cnt), 32'd3);
    chk("perf_state", 32'(state_dbg), 32'd1);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
